// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: loads a tap set over valid/ready and swaps it into the FIR atomically on a sample boundary
module fir_coeff_sequencer #(
    parameter int N = 4,
    parameter int COEFF_WIDTH = 8,
    parameter logic [N*COEFF_WIDTH-1:0] RESET_COEFFS = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COEFF_WIDTH-1:0]   coeff_in,
    input  logic                     coeff_valid,
    output logic                     coeff_ready,
    input  logic                     sample_en,
    output logic [N*COEFF_WIDTH-1:0] packed_coeffs,
    output logic                     busy,
    output logic                     updated,
    output logic [$clog2(N+1)-1:0]   coeff_count
);
    localparam int CW = $clog2(N+1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2;
    logic [1:0] state;
    logic [N*COEFF_WIDTH-1:0] shadow;
    assign coeff_ready = state == LOAD;
    assign busy = state != IDLE;
    // Sequencer: abort beats transfer and swap; the active set only ever takes a whole shadow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            packed_coeffs <= RESET_COEFFS;
            shadow <= '0;
            coeff_count <= '0;
            updated <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    state <= IDLE;
                    shadow <= '0;
                end
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= LOAD;
                        coeff_count <= '0;
                    end
                    LOAD: if (coeff_valid) begin
                        shadow[(N-int'(coeff_count))*COEFF_WIDTH-1 -: COEFF_WIDTH] <= coeff_in;
                        coeff_count <= coeff_count + CW'(1);
                        if (coeff_count == CW'(N-1)) state <= ARMED;
                    end
                    ARMED: if (sample_en) begin
                        packed_coeffs <= shadow;
                        updated <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// tb_fir_coeff_sequencer: randomized load/abort/swap traffic with a scoreboard of expected tap-set swaps
module tb_fir_coeff_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0, coeff_valid = 1'b0, sample_en = 1'b0;
    logic [7:0] coeff_in = '0;
    logic coeff_ready, busy, updated;
    logic [31:0] packed_coeffs;
    logic [2:0] coeff_count;
    int checks = 0, errors = 0;
    logic [31:0] model = '0;
    logic [31:0] swap_q[$];

    fir_coeff_sequencer #(.N(4), .COEFF_WIDTH(8), .RESET_COEFFS(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .coeff_in(coeff_in),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .sample_en(sample_en),
        .packed_coeffs(packed_coeffs), .busy(busy), .updated(updated), .coeff_count(coeff_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every updated pulse must match the next queued swap; any other change of the active set is an error
    initial begin
        logic [31:0] prev;
        prev = packed_coeffs;
        forever begin
            @(negedge clk);
            if (!rst_n) prev = packed_coeffs;
            else begin
                if (updated) begin
                    if (swap_q.size() == 0) chk("spurious_updated", {31'b0, updated}, 32'h0);
                    else chk("swap_value", packed_coeffs, swap_q.pop_front());
                end else chk("no_change_without_updated", packed_coeffs, prev);
                prev = packed_coeffs;
            end
        end
    end

    // One load transaction: set holds coefficients in arrival order (first in MSBs);
    // abort_after = number accepted before abort (-1: none); armed_abort aborts in ARMED instead of swapping
    task automatic load_txn(input logic [31:0] set, input int abort_after, input bit coincide, input bit armed_abort);
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'h1);
        chk("count_cleared", {29'b0, coeff_count}, 32'h0);
        k = 0;
        while (k < 4) begin
            if (abort_after == k) begin
                abort = 1'b1;
                coeff_valid = 1'($urandom % 2);
                coeff_in = set[31-8*k -: 8];
                tick();
                abort = 1'b0;
                coeff_valid = 1'b0;
                chk("abort_load_idle", {31'b0, busy}, 32'h0);
                chk("abort_load_active", packed_coeffs, model);
                return;
            end
            coeff_valid = $urandom_range(0, 2) != 0;
            coeff_in = coeff_valid ? set[31-8*k -: 8] : 8'($urandom);
            start = ($urandom % 4) == 0;
            sample_en = (coincide && k == 3) ? 1'b1 : 1'($urandom % 2);
            chk("ready_in_load", {31'b0, coeff_ready}, 32'h1);
            tick();
            if (coeff_valid) k++;
            chk("count_progress", {29'b0, coeff_count}, 32'(k));
        end
        coeff_valid = 1'b0;
        sample_en = 1'b0;
        start = 1'b0;
        chk("armed_not_ready", {31'b0, coeff_ready}, 32'h0);
        chk("armed_busy", {31'b0, busy}, 32'h1);
        chk("armed_no_swap_yet", packed_coeffs, model);
        repeat ($urandom_range(0, 2)) begin
            start = 1'($urandom % 2);
            tick();
            start = 1'b0;
        end
        if (armed_abort) begin
            abort = 1'b1;
            sample_en = 1'($urandom % 2);
            tick();
            abort = 1'b0;
            sample_en = 1'b0;
            chk("abort_armed_idle", {31'b0, busy}, 32'h0);
            chk("abort_armed_active", packed_coeffs, model);
        end else begin
            sample_en = 1'b1;
            model = set;
            swap_q.push_back(set);
            tick();
            sample_en = 1'b0;
            chk("swap_idle", {31'b0, busy}, 32'h0);
            chk("swap_count_held", {29'b0, coeff_count}, 32'h4);
            chk("swap_active", packed_coeffs, model);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_packed", packed_coeffs, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_ready", {31'b0, coeff_ready}, 32'h0);
        chk("reset_updated", {31'b0, updated}, 32'h0);
        chk("reset_count", {29'b0, coeff_count}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        load_txn(32'h0403FFFE, -1, 1'b0, 1'b0);
        load_txn(32'h01020304, -1, 1'b1, 1'b0);
        load_txn(32'h0403FFFE, -1, 1'b0, 1'b0);
        load_txn(32'h07070000, 2, 1'b0, 1'b0);
        load_txn(32'h05060708, -1, 1'b0, 1'b0);
        load_txn(32'h11223344, -1, 1'b0, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 30; i++) begin
            logic [31:0] s;
            int mode;
            s = $urandom;
            mode = $urandom_range(0, 5);
            load_txn(s, mode == 0 ? int'($urandom_range(0, 3)) : -1, 1'($urandom % 2), mode == 1);
            repeat ($urandom_range(0, 2)) begin
                abort = 1'($urandom % 2);
                tick();
                abort = 1'b0;
            end
            chk("idle_between", {31'b0, busy}, 32'h0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            coeff_valid = 1'b1;
            coeff_in = 8'h5A;
            tick();
        end
        coeff_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model = 32'h0;
        chk("async_reset_packed", packed_coeffs, model);
        chk("async_reset_busy", {31'b0, busy}, 32'h0);
        chk("async_reset_count", {29'b0, coeff_count}, 32'h0);
        chk("async_reset_ready", {31'b0, coeff_ready}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        load_txn(32'h80FF7F01, -1, 1'b0, 1'b0);
        repeat (2) tick();
        chk("scoreboard_drained", 32'(swap_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
